// File: rtl/alu_pkg.sv
// Shared types and decode constants for the handshaked EX-stage ALU.
// Imported by alu_pipe and alu_mul_iter.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SLL  = 4'b0011,
        OP_MUL  = 4'b0100,
        OP_BEQ  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SRL  = 4'b0111,
        OP_BLT  = 4'b1000,
        OP_SRA  = 4'b1001,
        OP_BGE  = 4'b1010,
        OP_BLTU = 4'b1011,
        OP_NOR  = 4'b1100,
        OP_BGEU = 4'b1101,
        OP_JAL  = 4'b1110,
        OP_XOR  = 4'b1111
    } alu_op_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } alu_state_t;

    // One bit per opcode: set for BEQ, BLT, BGE, BLTU, BGEU.
    localparam logic [15:0] BRANCH_OPS = 16'h2D20;

    function automatic logic is_branch(input alu_op_t op);
        return BRANCH_OPS[op];
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// WIDTH steps, low WIDTH bits of the product held on prod once done.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] prod
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;

    // Down-counter of remaining steps; the result stays parked at zero count.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            cnt    <= CW'(WIDTH);
        end else if (cnt != '0) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);
    assign prod = acc;

endmodule

// File: rtl/alu_pipe.sv
// EX-stage ALU with valid/ready issue, a one-entry output register and an
// iterative multiplier; result and zero always describe the same operation.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | ready for issue when the output register is free
// S_MUL  | shift-add multiply running, or finished and waiting to unload
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    alu_state_t       state;
    alu_state_t       state_nxt;
    alu_op_t          op_e;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] res_c;
    logic             cond_c;
    logic             zero_c;
    logic             out_free;
    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_prod;
    logic             load_alu;
    logic             load_mul;

    assign op_e      = alu_op_t'(op);
    assign shamt     = b[SHW-1:0];
    assign out_free  = !out_valid || out_ready;
    assign in_ready  = (state == S_IDLE) && out_free;
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op_e == OP_MUL);
    assign load_alu  = accept && (op_e != OP_MUL);
    assign load_mul  = (state == S_MUL) && mul_done && out_free;
    assign busy      = (state == S_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .reset (reset),
        .start (mul_start),
        .a     (a),
        .b     (b),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    // Branches yield result 0; only branches and JAL may raise zero.
    always_comb begin
        res_c  = '0;
        cond_c = 1'b0;
        case (op_e)
            OP_AND:  res_c  = a & b;
            OP_OR:   res_c  = a | b;
            OP_ADD:  res_c  = a + b;
            OP_SUB:  res_c  = a - b;
            OP_SLL:  res_c  = a << shamt;
            OP_SRL:  res_c  = a >> shamt;
            OP_SRA:  res_c  = $signed(a) >>> shamt;
            OP_NOR:  res_c  = ~(a | b);
            OP_XOR:  res_c  = a ^ b;
            OP_BEQ:  cond_c = (a == b);
            OP_BLT:  cond_c = ($signed(a) < $signed(b));
            OP_BGE:  cond_c = ($signed(a) >= $signed(b));
            OP_BLTU: cond_c = (a < b);
            OP_BGEU: cond_c = (a >= b);
            default: res_c  = '0;
        endcase
        zero_c = is_branch(op_e) ? cond_c : (op_e == OP_JAL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (mul_start) state_nxt = S_MUL;
            S_MUL:   if (load_mul)  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
        end else if (load_alu) begin
            out_valid <= 1'b1;
            result    <= res_c;
            zero      <= zero_c;
        end else if (load_mul) begin
            out_valid <= 1'b1;
            result    <= mul_prod;
            zero      <= 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: a 64-bit instance for most steps and a
// 32-bit instance for the narrow multiply.
module tb_alu_pipe;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, out_ready;
    logic [3:0]  op;
    logic [63:0] a, b;
    logic        in_ready, out_valid, zero, busy;
    logic [63:0] result;

    logic        in_valid32, out_ready32;
    logic [3:0]  op32;
    logic [31:0] a32, b32;
    logic        in_ready32, out_valid32, zero32, busy32;
    logic [31:0] result32;

    int checks = 0;
    int errors = 0;
    int n, bad;
    logic [63:0] held;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(64)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .busy(busy)
    );

    alu_pipe #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid32), .in_ready(in_ready32),
        .op(op32), .a(a32), .b(b32), .out_valid(out_valid32), .out_ready(out_ready32),
        .result(result32), .zero(zero32), .busy(busy32)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input alu_op_t o, input logic [63:0] x, input logic [63:0] y);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        tick();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 4'd0; a = '0; b = '0;
        in_valid32 = 1'b0; out_ready32 = 1'b1; op32 = 4'd0; a32 = '0; b32 = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_busy", {63'd0, busy}, 64'd0);

        // Reset in the middle of a multiply discards it.
        issue(OP_MUL, 64'd3, 64'd5);
        in_valid = 1'b0;
        check("mul_busy", {63'd0, busy}, 64'd1);
        check("mul_in_ready", {63'd0, in_ready}, 64'd0);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_result", result, 64'd0);
        check("midrst_zero", {63'd0, zero}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            if (out_valid) bad++;
            tick();
        end
        check("midrst_no_late", 64'(bad), 64'd0);

        // Back-to-back single-cycle ops.
        issue(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        check("add_valid", {63'd0, out_valid}, 64'd1);
        check("add_wrap", result, 64'd0);
        check("add_zero", {63'd0, zero}, 64'd0);
        issue(OP_SUB, 64'd5, 64'd7);
        check("sub", result, 64'hFFFF_FFFF_FFFF_FFFE);
        issue(OP_SRA, 64'h8000_0000_0000_0000, 64'd4);
        check("sra", result, 64'hF800_0000_0000_0000);
        issue(OP_SLL, 64'd1, 64'h41);
        check("sll_mask", result, 64'd2);
        issue(OP_SRL, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF04);
        check("srl", result, 64'h0800_0000_0000_0000);
        issue(OP_NOR, 64'h0F0F, 64'h00F0);
        check("nor", result, 64'hFFFF_FFFF_FFFF_F000);
        issue(OP_XOR, 64'hFF00, 64'h0FF0);
        check("xor", result, 64'h0000_0000_0000_F0F0);
        issue(OP_AND, 64'hFF00, 64'h0FF0);
        check("and", result, 64'h0000_0000_0000_0F00);

        // Branches and jump.
        issue(OP_BLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        check("blt_zero", {63'd0, zero}, 64'd1);
        check("blt_result", result, 64'd0);
        issue(OP_BLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        check("bltu_zero", {63'd0, zero}, 64'd0);
        issue(OP_BGE, 64'd7, 64'd7);
        check("bge_zero", {63'd0, zero}, 64'd1);
        issue(OP_BEQ, 64'd3, 64'd4);
        check("beq_zero", {63'd0, zero}, 64'd0);
        issue(OP_BGEU, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        check("bgeu_zero", {63'd0, zero}, 64'd0);
        issue(OP_JAL, 64'd9, 64'd9);
        check("jal_zero", {63'd0, zero}, 64'd1);
        check("jal_result", result, 64'd0);
        issue(OP_ADD, 64'd2, 64'd3);
        check("add_after_jal_zero", {63'd0, zero}, 64'd0);
        check("add_after_jal_res", result, 64'd5);
        in_valid = 1'b0;
        tick();
        check("pop_clear_valid", {63'd0, out_valid}, 64'd0);
        check("pop_clear_result", result, 64'd0);

        // Multiply latency and result.
        issue(OP_MUL, 64'h1234, 64'h10);
        in_valid = 1'b0;
        n = 0; bad = 0;
        while (!out_valid && n < 200) begin
            if (in_ready) bad++;
            tick();
            n++;
        end
        check("mul_latency", 64'(n), 64'd65);
        check("mul_in_ready_low", 64'(bad), 64'd0);
        check("mul_result", result, 64'h12340);
        check("mul_zero", {63'd0, zero}, 64'd0);
        check("mul_busy_after", {63'd0, busy}, 64'd0);
        tick();

        // Backpressure: result held, then pop and accept in the same cycle.
        out_ready = 1'b0;
        issue(OP_ADD, 64'd10, 64'd20);
        op = OP_SUB; a = 64'd100; b = 64'd1;
        held = result;
        check("bp_result", held, 64'd30);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (in_ready || !out_valid || result !== held) bad++;
            tick();
        end
        check("bp_stable", 64'(bad), 64'd0);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        check("bp_replace_valid", {63'd0, out_valid}, 64'd1);
        check("bp_replace_result", result, 64'd99);
        tick();
        check("bp_drain", {63'd0, out_valid}, 64'd0);

        // Narrow build multiply.
        in_valid32 = 1'b1; op32 = OP_MUL; a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF;
        tick();
        in_valid32 = 1'b0;
        n = 0;
        while (!out_valid32 && n < 200) begin
            tick();
            n++;
        end
        check("mul32_latency", 64'(n), 64'd33);
        check("mul32_result", {32'd0, result32}, 64'd1);
        check("mul32_zero", {63'd0, zero32}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
